instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
Instruction-fetch stage of the 4-stage pipeline. It is the producer of the opcode and register fields that the decode/control logic consumes, and the consumer of that logic's PC_Select (jump-taken) signal. It holds the PC, a loadable instruction memory and the IF/ID pipeline register. On a taken jump it redirects the PC to the jump target and flushes IF/ID with a bubble.

Parameters:
PC_WIDTH, 8, PC and instruction-memory address width; memory depth is 2**PC_WIDTH.
INSTR_WIDTH, 8, instruction width; fields are opcode [7:6], Write_Reg [5:3], Read_Reg [2:0].

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
Prog_En  in  1  program mode: fetch halted, memory writable
Prog_We  in  1  memory write strobe; honoured only while Prog_En=1
Prog_Addr  in  PC_WIDTH  memory write address
Prog_Data  in  INSTR_WIDTH  memory write data
Stall  in  1  hold PC and IF/ID (hazard stall from downstream)
PC_Select  in  1  jump taken in EX; redirect and flush
Branch_Target  in  PC_WIDTH  jump target, valid when PC_Select=1
PC_out  out  PC_WIDTH  current fetch address
Instr_ID  out  INSTR_WIDTH  IF/ID instruction register
Valid_ID  out  1  Instr_ID holds a real instruction (0 = bubble)
opcode  out  2  Instr_ID[7:6], combinational slice
Write_Reg_ID  out  3  Instr_ID[5:3], combinational slice

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset). All state updates occur on the rising edge of clk.
- Reset values:
  - PC_out = 0
  - Instr_ID = 8'h00
  - Valid_ID = 0
  - Instruction memory contents are NOT cleared by reset.
- Memory: synchronous write; asynchronous read of imem[PC_out].
- Per-edge priority, highest first:
  1. reset: apply the reset values above.
  2. Prog_En=1:
     - PC <= 0; Instr_ID <= 8'h00; Valid_ID <= 0.
     - If Prog_We=1: imem[Prog_Addr] <= Prog_Data.
  3. PC_Select=1:
     - PC <= Branch_Target; Instr_ID <= 8'h00; Valid_ID <= 0.
     - This overrides Stall in the same cycle.
  4. Stall=1: PC, Instr_ID and Valid_ID hold.
  5. Normal fetch: Instr_ID <= imem[PC]; Valid_ID <= 1; PC <= PC+1.
- Latency: the instruction at address A appears on Instr_ID at the edge after PC_out==A, i.e. one cycle.
- PC arithmetic: modulo 2**PC_WIDTH. PC 255 wraps to 0 with no flag and no stall.
- Prog_We with Prog_En=0 is ignored, so the memory cannot be written while fetch is running.
- Leaving program mode: the first cycle with Prog_En=0 fetches address 0. Valid_ID goes to 1 on the following edge.
- Prog_En asserted mid-run aborts the current fetch. Pending Stall or PC_Select in that cycle is ignored.
- Bubble definition:
  - A bubble is Valid_ID=0 with Instr_ID=8'h00.
  - Downstream must gate RegWrite with Valid_ID, because 8'h00 decodes as opcode 00, which writes a register.
- Back-to-back PC_Select on consecutive cycles: each redirect takes effect and Valid_ID stays 0 throughout.
- opcode and Write_Reg_ID are pure slices of Instr_ID, so they also carry bubble values during a flush.

Decomposition:
- Shared package (cpu_pkg):
  - PC_WIDTH and INSTR_WIDTH.
  - Opcode constants OP_ADD=2'b00, OP_SHIFT=2'b01, OP_JUMP=2'b11.
  - BUBBLE_INSTR=8'h00.
  - Field position constants.
- One sub-module, instr_mem: 2**PC_WIDTH x INSTR_WIDTH, synchronous write, asynchronous read.

Test Plan:
- Reset then run: load imem[0..3]=8'h08,8'h51,8'h92,8'hD3, drop Prog_En, reset for 1 cycle.
  -> PC_out steps 0,1,2,3.
  -> Instr_ID = 08,51,92,D3 on consecutive edges, one cycle behind PC.
  -> Valid_ID=1 from the second edge; opcode follows 0,1,2,3.
- Stall: assert Stall 2 cycles while PC=2.
  -> PC_out holds 2 and Instr_ID holds 51.
  -> Resumes with 92 the cycle after Stall drops.
- Jump flush: PC_Select=1, Branch_Target=8'h40 at PC=3.
  -> Next edge: PC_out=40, Instr_ID=00, Valid_ID=0.
  -> Following edge: Instr_ID=imem[40h], Valid_ID=1.
- Simultaneous Stall=1 and PC_Select=1, Branch_Target=8'h10.
  -> PC_out=10 and bubble inserted; the stall is ignored.
- Wrap: Branch_Target=8'hFF, then normal fetch.
  -> PC_out FF then 00; Instr_ID=imem[FF] then imem[00].
- Program mode mid-run: Prog_En=1 at PC=5 with Prog_We=1, Prog_Addr=5, Prog_Data=8'hC7.
  -> PC_out=0 and Valid_ID=0 while Prog_En=1.
  -> After release, fetching from address 5 returns C7.
  -> Prog_We=1 with Prog_En=0 leaves memory unchanged.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared widths, opcode encodings and instruction field positions for the
// 4-stage pipeline.
package cpu_pkg;

  localparam int unsigned PC_WIDTH    = 8;
  localparam int unsigned INSTR_WIDTH = 8;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SHIFT = 2'b01;
  localparam logic [1:0] OP_JUMP  = 2'b11;

  // All-zero instruction used as a bubble; only Valid_ID separates it from a real ADD.
  localparam logic [INSTR_WIDTH-1:0] BUBBLE_INSTR = 8'h00;

  localparam int unsigned OPC_MSB = 7;
  localparam int unsigned OPC_LSB = 6;
  localparam int unsigned WR_MSB  = 5;
  localparam int unsigned WR_LSB  = 3;
  localparam int unsigned RR_MSB  = 2;
  localparam int unsigned RR_LSB  = 0;

endpackage

// File: rtl/instr_mem.sv
// Instruction memory: 2**ADDR_WIDTH x DATA_WIDTH, synchronous write,
// asynchronous read. Contents have no reset.
// Ports: clk, we_i/waddr_i/wdata_i (write port), raddr_i -> rdata_o (read port).
module instr_mem #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read port
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: PC, loadable instruction memory and IF/ID register.
// A taken jump (PC_Select) redirects the PC and flushes IF/ID with a bubble.
// Ports:
//   clk, reset (sync, active-high)
//   Prog_En/Prog_We/Prog_Addr/Prog_Data : program-mode memory load
//   Stall, PC_Select, Branch_Target     : pipeline control from downstream
//   PC_out, Instr_ID, Valid_ID          : registered fetch state
//   opcode, Write_Reg_ID                : combinational slices of Instr_ID
module instr_fetch_unit #(
  parameter int unsigned PC_WIDTH    = cpu_pkg::PC_WIDTH,
  parameter int unsigned INSTR_WIDTH = cpu_pkg::INSTR_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   Prog_En,
  input  logic                   Prog_We,
  input  logic [PC_WIDTH-1:0]    Prog_Addr,
  input  logic [INSTR_WIDTH-1:0] Prog_Data,
  input  logic                   Stall,
  input  logic                   PC_Select,
  input  logic [PC_WIDTH-1:0]    Branch_Target,
  output logic [PC_WIDTH-1:0]    PC_out,
  output logic [INSTR_WIDTH-1:0] Instr_ID,
  output logic                   Valid_ID,
  output logic [1:0]             opcode,
  output logic [2:0]             Write_Reg_ID
);

  import cpu_pkg::*;

  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic                   valid_q, valid_d;
  logic [INSTR_WIDTH-1:0] imem_rdata;
  logic                   imem_we;

  // Reset wins over program mode; writes only while fetch is halted.
  assign imem_we = Prog_En & Prog_We & ~reset;

  instr_mem #(
    .ADDR_WIDTH (PC_WIDTH),
    .DATA_WIDTH (INSTR_WIDTH)
  ) u_imem (
    .clk     (clk),
    .we_i    (imem_we),
    .waddr_i (Prog_Addr),
    .wdata_i (Prog_Data),
    .raddr_i (pc_q),
    .rdata_o (imem_rdata)
  );

  // Next-state priority: program mode > jump redirect > stall > fetch.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (Prog_En) begin
      pc_d    = '0;
      instr_d = BUBBLE_INSTR;
      valid_d = 1'b0;
    end else if (PC_Select) begin
      pc_d    = Branch_Target;
      instr_d = BUBBLE_INSTR;
      valid_d = 1'b0;
    end else if (!Stall) begin
      pc_d    = pc_q + PC_WIDTH'(1);
      instr_d = imem_rdata;
      valid_d = 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= '0;
      instr_q <= BUBBLE_INSTR;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign PC_out       = pc_q;
  assign Instr_ID     = instr_q;
  assign Valid_ID     = valid_q;
  assign opcode       = instr_q[OPC_MSB:OPC_LSB];
  assign Write_Reg_ID = instr_q[WR_MSB:WR_LSB];

endmodule
